// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default operand width.
package serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor; the only arithmetic element of the serial subtractor.
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin: one fs_cell iterated LSB first over WIDTH cycles, result held until taken.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_width_check
    $error("serial_subtractor: WIDTH must be within 1..32");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic             bout_q;
  logic             zero_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] b_d;
  logic [WIDTH-1:0] res_d;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  fs_cell u_fs_cell (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // Next shift-register contents; the diff bit enters the result from the MSB side.
  always_comb begin
    a_d            = a_q >> 1;
    b_d            = b_q >> 1;
    res_d          = res_q >> 1;
    res_d[WIDTH-1] = cell_d;
  end

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            borrow_q   <= bin;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          a_q      <= a_d;
          b_q      <= b_d;
          res_q    <= res_d;
          borrow_q <= cell_bo;
          cnt_q    <= cnt_q + 1'b1;
          // Publish on the final bit so out_valid rises exactly as SHIFT ends.
          if (last_bit) begin
            diff_q      <= res_d;
            bout_q      <= cell_bo;
            zero_q      <= (res_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign zero      = zero_q;

endmodule
